// File: rtl/rv_pkg.sv
// Shared decode-stage constants: register file geometry, IF2->ID payload width
// and the bit offsets of each bypass channel inside the packed bypass buses.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int NREG       = 32;
    localparam int PAYLOAD_WD = 64;

    function automatic int byp_addr_lo(input int k);
        return k * REG_AW;
    endfunction

    function automatic int byp_data_lo(input int k, input int xlen);
        return k * xlen;
    endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Bypass bus from the younger pipeline stages into the operand-fetch stage.
// Each channel k has a destination, a result and a ready flag, all packed.
interface id_operand_stage_if #(
    parameter int NBYP = 4,
    parameter int XLEN = rv_pkg::XLEN
);
    logic [NBYP-1:0]               byp_we;
    logic [NBYP*rv_pkg::REG_AW-1:0] byp_addr;
    logic [NBYP*XLEN-1:0]          byp_data;
    logic [NBYP-1:0]               byp_rdy;

    modport master (output byp_we, output byp_addr, output byp_data, output byp_rdy);
    modport slave  (input  byp_we, input  byp_addr, input  byp_data, input  byp_rdy);
endinterface

// File: rtl/id_fwd_mux.sv
// Priority operand select: the youngest matching channel owns the register,
// even when its result is not ready yet (an older value would be stale).
module id_fwd_mux #(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int NBYP = 4
) (
    input  logic [rv_pkg::REG_AW-1:0]      rs,
    input  logic [NBYP-1:0]                byp_we,
    input  logic [NBYP*rv_pkg::REG_AW-1:0] byp_addr,
    input  logic [NBYP*XLEN-1:0]           byp_data,
    input  logic [NBYP-1:0]                byp_rdy,
    input  logic [XLEN-1:0]                rf_rdata,
    output logic [XLEN-1:0]                opnd,
    output logic                           fwd_hit,
    output logic                           fwd_hz
);
    import rv_pkg::*;

    logic [NBYP-1:0] match;
    logic            found;

    generate
        for (genvar gi = 0; gi < NBYP; gi++) begin : g_match
            assign match[gi] = byp_we[gi] && (rs != '0) &&
                               (byp_addr[byp_addr_lo(gi) +: REG_AW] == rs);
        end
    endgenerate

    always_comb begin
        opnd    = (rs == '0) ? '0 : rf_rdata;
        fwd_hit = 1'b0;
        fwd_hz  = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < NBYP; k++) begin
            if (!found && match[k]) begin
                found = 1'b1;
                if (byp_rdy[k]) begin
                    opnd    = byp_data[byp_data_lo(k, XLEN) +: XLEN];
                    fwd_hit = 1'b1;
                end else begin
                    fwd_hz  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: IF2->ID pipeline register, per-operand bypass
// resolution, long-latency busy scoreboard and a saturating stall counter.
module id_operand_stage #(
    parameter int XLEN       = rv_pkg::XLEN,
    parameter int NBYP       = 4,
    parameter int PAYLOAD_WD = rv_pkg::PAYLOAD_WD,
    parameter int SCNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall_in,
    input  logic                      stall_next,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [PAYLOAD_WD-1:0]     in_payload,
    output logic                      id_valid,
    output logic [PAYLOAD_WD-1:0]     id_payload,
    input  logic [rv_pkg::REG_AW-1:0] dec_rs1,
    input  logic [rv_pkg::REG_AW-1:0] dec_rs2,
    input  logic                      dec_use1,
    input  logic                      dec_use2,
    input  logic [XLEN-1:0]           rf_rdata1,
    input  logic [XLEN-1:0]           rf_rdata2,
    id_operand_stage_if.slave         byp,
    input  logic                      sb_set,
    input  logic [rv_pkg::REG_AW-1:0] sb_set_rd,
    input  logic                      sb_clr,
    input  logic [rv_pkg::REG_AW-1:0] sb_clr_rd,
    output logic [XLEN-1:0]           opnd1,
    output logic [XLEN-1:0]           opnd2,
    output logic                      stallreq,
    output logic [SCNT_W-1:0]         stall_cycles
);
    import rv_pkg::*;

    logic                  id_valid_reg;
    logic [PAYLOAD_WD-1:0] id_payload_reg;
    logic [NREG-1:0]       busy_reg, busy_next;
    logic [SCNT_W-1:0]     scnt_reg;
    logic                  hit1, hit2, nr1, nr2, hz1, hz2;

    id_fwd_mux #(.XLEN(XLEN), .NBYP(NBYP)) u_fwd1 (
        .rs(dec_rs1), .byp_we(byp.byp_we), .byp_addr(byp.byp_addr),
        .byp_data(byp.byp_data), .byp_rdy(byp.byp_rdy), .rf_rdata(rf_rdata1),
        .opnd(opnd1), .fwd_hit(hit1), .fwd_hz(nr1)
    );

    id_fwd_mux #(.XLEN(XLEN), .NBYP(NBYP)) u_fwd2 (
        .rs(dec_rs2), .byp_we(byp.byp_we), .byp_addr(byp.byp_addr),
        .byp_data(byp.byp_data), .byp_rdy(byp.byp_rdy), .rf_rdata(rf_rdata2),
        .opnd(opnd2), .fwd_hit(hit2), .fwd_hz(nr2)
    );

    // A busy register is only usable in the cycle its writeback is on a ready channel.
    assign hz1      = nr1 || (busy_reg[dec_rs1] && !hit1);
    assign hz2      = nr2 || (busy_reg[dec_rs2] && !hit2);
    assign stallreq = id_valid_reg && ((dec_use1 && hz1) || (dec_use2 && hz2));

    // Set is applied after clear so a new owner survives a same-cycle release.
    always_comb begin
        busy_next = busy_reg;
        if (sb_clr) busy_next[sb_clr_rd] = 1'b0;
        if (sb_set) busy_next[sb_set_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid_reg   <= 1'b0;
            id_payload_reg <= '0;
            busy_reg       <= '0;
            scnt_reg       <= '0;
        end else begin
            if (flush || (stall_in && !stall_next)) begin
                id_valid_reg   <= 1'b0;
                id_payload_reg <= '0;
            end else if (!stall_in) begin
                id_valid_reg   <= in_valid;
                id_payload_reg <= in_payload;
            end
            busy_reg <= busy_next;
            if (stallreq && (scnt_reg != '1))
                scnt_reg <= scnt_reg + SCNT_W'(1);
        end
    end

    assign id_valid     = id_valid_reg;
    assign id_payload   = id_payload_reg;
    assign stall_cycles = scnt_reg;
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: bypass priority, x0, scoreboard,
// pipeline register control and the saturating stall counter (4-bit here).
module tb_id_operand_stage;
    localparam int XLEN = 32;
    localparam int NBYP = 4;
    localparam int PW   = 64;
    localparam int SCW  = 4;

    logic            clk = 1'b0;
    logic            rst_n, stall_in, stall_next, flush, in_valid;
    logic [PW-1:0]   in_payload, id_payload;
    logic            id_valid;
    logic [4:0]      dec_rs1, dec_rs2, sb_set_rd, sb_clr_rd;
    logic            dec_use1, dec_use2, sb_set, sb_clr, stallreq;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2, opnd1, opnd2;
    logic [SCW-1:0]  stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    id_operand_stage_if #(.NBYP(NBYP), .XLEN(XLEN)) byp_bus ();

    id_operand_stage #(.XLEN(XLEN), .NBYP(NBYP), .PAYLOAD_WD(PW), .SCNT_W(SCW)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .stall_next(stall_next),
        .flush(flush), .in_valid(in_valid), .in_payload(in_payload),
        .id_valid(id_valid), .id_payload(id_payload),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use1(dec_use1), .dec_use2(dec_use2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .byp(byp_bus.slave),
        .sb_set(sb_set), .sb_set_rd(sb_set_rd), .sb_clr(sb_clr), .sb_clr_rd(sb_clr_rd),
        .opnd1(opnd1), .opnd2(opnd2), .stallreq(stallreq), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic we, input logic [4:0] a,
                          input logic [XLEN-1:0] d, input logic r);
        byp_bus.byp_we[k]            = we;
        byp_bus.byp_addr[k*5 +: 5]   = a;
        byp_bus.byp_data[k*XLEN +: XLEN] = d;
        byp_bus.byp_rdy[k]           = r;
    endtask

    task automatic clr_byp();
        byp_bus.byp_we   = '0;
        byp_bus.byp_addr = '0;
        byp_bus.byp_data = '0;
        byp_bus.byp_rdy  = '0;
    endtask

    initial begin
        rst_n = 1'b0; stall_in = 1'b0; stall_next = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_payload = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_use1 = 1'b0; dec_use2 = 1'b0;
        rf_rdata1 = 32'hAAAA_0001; rf_rdata2 = 32'hBBBB_0002;
        sb_set = 1'b0; sb_set_rd = '0; sb_clr = 1'b0; sb_clr_rd = '0;
        clr_byp();

        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 64'(id_valid), 64'd0);
        chk("rst_payload", id_payload, 64'd0);
        chk("rst_scnt", 64'(stall_cycles), 64'd0);
        chk("rst_stallreq", 64'(stallreq), 64'd0);

        // Load a live instruction; stall_in stays low so ID keeps reloading.
        in_valid = 1'b1; in_payload = 64'h0000_1000_0000_0013;
        tick();
        chk("load_valid", 64'(id_valid), 64'd1);
        chk("load_payload", id_payload, 64'h0000_1000_0000_0013);

        // 1: youngest ready channel wins over an older one.
        set_ch(0, 1'b1, 5'd5, 32'h11, 1'b1);
        set_ch(2, 1'b1, 5'd5, 32'h22, 1'b1);
        dec_rs1 = 5'd5; dec_use1 = 1'b1;
        #1;
        chk("t1_opnd1", 64'(opnd1), 64'h11);
        chk("t1_stall", 64'(stallreq), 64'd0);
        dec_rs1 = 5'd6;
        #1;
        chk("rf_fallthru", 64'(opnd1), 64'hAAAA_0001);

        // 2: youngest match not ready -> hazard, no fall-through to ch1.
        clr_byp(); dec_rs1 = 5'd0;
        set_ch(0, 1'b1, 5'd7, 32'h70, 1'b0);
        set_ch(1, 1'b1, 5'd7, 32'h71, 1'b1);
        dec_rs2 = 5'd7; dec_use2 = 1'b1;
        #1;
        chk("t2_stall_use", 64'(stallreq), 64'd1);
        dec_use2 = 1'b0;
        #1;
        chk("t2_stall_nouse", 64'(stallreq), 64'd0);

        // 3: x0 always reads zero.
        clr_byp(); dec_rs2 = 5'd0;
        set_ch(0, 1'b1, 5'd0, 32'hDEAD, 1'b1);
        dec_rs1 = 5'd0; dec_use1 = 1'b1;
        #1;
        chk("t3_opnd1", 64'(opnd1), 64'd0);
        chk("t3_stall", 64'(stallreq), 64'd0);

        // 4: scoreboard set, hold, forwarded writeback, clear.
        clr_byp(); dec_rs1 = 5'd1;
        sb_set = 1'b1; sb_set_rd = 5'd9;
        tick();
        sb_set = 1'b0; dec_rs1 = 5'd9;
        #1;
        chk("t4_busy_stall", 64'(stallreq), 64'd1);
        tick();
        chk("t4_busy_hold", 64'(stallreq), 64'd1);
        sb_clr = 1'b1; sb_clr_rd = 5'd9;
        set_ch(3, 1'b1, 5'd9, 32'h99, 1'b1);
        #1;
        chk("t4_wb_stall", 64'(stallreq), 64'd0);
        chk("t4_wb_opnd1", 64'(opnd1), 64'h99);
        tick();
        sb_clr = 1'b0; clr_byp();
        #1;
        chk("t4_cleared", 64'(stallreq), 64'd0);
        sb_set = 1'b1; sb_clr = 1'b1;
        tick();
        sb_set = 1'b0; sb_clr = 1'b0;
        #1;
        chk("t4_setclr_busy", 64'(stallreq), 64'd1);
        sb_clr = 1'b1;
        tick();
        sb_clr = 1'b0; dec_use1 = 1'b0;
        #1;
        chk("t4_release", 64'(stallreq), 64'd0);

        // 5: pipeline register control.
        stall_in = 1'b1; stall_next = 1'b0;
        tick();
        chk("t5_bubble", 64'(id_valid), 64'd0);
        stall_in = 1'b0; in_payload = 64'h0000_2000_0000_00B3;
        tick();
        chk("t5_reload", id_payload, 64'h0000_2000_0000_00B3);
        stall_in = 1'b1; stall_next = 1'b1; in_payload = 64'h0000_3000_0000_0033;
        tick();
        chk("t5_hold_pl", id_payload, 64'h0000_2000_0000_00B3);
        chk("t5_hold_vld", 64'(id_valid), 64'd1);
        stall_in = 1'b0; stall_next = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_vld", 64'(id_valid), 64'd0);
        chk("t5_flush_pl", id_payload, 64'd0);

        // 6: saturating counter and reset clearing the scoreboard.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_scnt0", 64'(stall_cycles), 64'd0);
        set_ch(0, 1'b1, 5'd5, 32'h55, 1'b0);
        dec_rs1 = 5'd5; dec_use1 = 1'b1;
        sb_set = 1'b1; sb_set_rd = 5'd12;
        for (int i = 1; i <= 20; i++) begin
            tick();
            sb_set = 1'b0;
            if (i == 3) chk("t6_scnt3", 64'(stall_cycles), 64'd3);
        end
        chk("t6_scnt_sat", 64'(stall_cycles), 64'd15);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; clr_byp(); dec_rs1 = 5'd12;
        #1;
        chk("t6_rst_scnt", 64'(stall_cycles), 64'd0);
        tick();
        chk("t6_rst_vld", 64'(id_valid), 64'd1);
        chk("t6_sb_cleared", 64'(stallreq), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
